// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - IF/ID pipeline register with valid/ready handshake, optional skid, flush and bubble counter
module if_id_pipe_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013),
  parameter int                 SKID_EN   = 1,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               if_valid_i,
  output logic               if_ready_o,
  input  logic [INSTR_W-1:0] if_instr_i,
  input  logic [PC_W-1:0]    if_pc_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [PC_W-1:0]    id_pc_o,
  output logic [CNT_W-1:0]   bubble_cnt_o,
  input  logic               bubble_clr_i
);

  logic               main_valid_q, main_valid_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [CNT_W-1:0]   bubble_q, bubble_d;
  logic               drain;
  logic               accept;

  // With a skid the ready is a pure flop; without it ready must look at the consumer.
  generate
    if (SKID_EN != 0) begin : g_skid_ready
      assign if_ready_o = !skid_valid_q;
    end else begin : g_comb_ready
      assign if_ready_o = !main_valid_q || id_ready_i;
    end
  endgenerate

  assign drain  = main_valid_q && id_ready_i;
  assign accept = if_valid_i && if_ready_o;

  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    bubble_d     = bubble_q;

    if (flush_i) begin
      main_valid_d = 1'b0;
      main_instr_d = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // Skid holds the older beat, so it always refills main before any new beat.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_instr_d = skid_instr_q;
        main_pc_d    = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_instr_d = if_instr_i;
        main_pc_d    = if_pc_i;
      end else begin
        main_valid_d = 1'b0;
        main_instr_d = NOP_INSTR;
      end
    end else if (accept && (SKID_EN != 0)) begin
      skid_valid_d = 1'b1;
      skid_instr_d = if_instr_i;
      skid_pc_d    = if_pc_i;
    end

    if (bubble_clr_i) begin
      bubble_d = '0;
    end else if (!main_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      bubble_q     <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      bubble_q     <= bubble_d;
    end
  end

  assign id_valid_o   = main_valid_q;
  assign id_instr_o   = main_instr_q;
  assign id_pc_o      = main_pc_q;
  assign bubble_cnt_o = bubble_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb/tb_if_id_pipe_reg.sv - self-checking bench for if_id_pipe_reg (skid/CNT_W=4 and no-skid instances)
module tb_if_id_pipe_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, vld, rdy, clr;
  logic [31:0] instr, pc;

  logic        a_ready, a_valid;
  logic [31:0] a_instr, a_pc;
  logic [3:0]  a_bub;
  logic        b_ready, b_valid;
  logic [31:0] b_instr, b_pc;
  logic [15:0] b_bub;

  if_id_pipe_reg #(.SKID_EN(1), .CNT_W(4)) u_skid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .if_valid_i(vld), .if_ready_o(a_ready), .if_instr_i(instr), .if_pc_i(pc),
    .id_valid_o(a_valid), .id_ready_i(rdy), .id_instr_o(a_instr), .id_pc_o(a_pc),
    .bubble_cnt_o(a_bub), .bubble_clr_i(clr)
  );

  if_id_pipe_reg #(.SKID_EN(0), .CNT_W(16)) u_noskid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .if_valid_i(vld), .if_ready_o(b_ready), .if_instr_i(instr), .if_pc_i(pc),
    .id_valid_o(b_valid), .id_ready_i(rdy), .id_instr_o(b_instr), .id_pc_o(b_pc),
    .bubble_cnt_o(b_bub), .bubble_clr_i(clr)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  // Reference: each DUT is a FIFO of held beats (capacity 2 with skid, 1 without).
  beat_t       qa[$];
  beat_t       qb[$];
  int          bub_a, bub_b;
  logic [31:0] lpc_a, lpc_b;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_check();
    chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
    chk("a_instr", a_instr, (qa.size() != 0) ? qa[0].instr : NOP);
    chk("a_pc", a_pc, lpc_a);
    chk("a_ready", 32'(a_ready), 32'(qa.size() < 2));
    chk("a_bub", 32'(a_bub), 32'(bub_a));
    chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
    chk("b_instr", b_instr, (qb.size() != 0) ? qb[0].instr : NOP);
    chk("b_pc", b_pc, lpc_b);
    chk("b_ready", 32'(b_ready), 32'((qb.size() == 0) || rdy));
    chk("b_bub", 32'(b_bub), 32'(bub_b));
  endtask

  task automatic model_edge();
    bit    ra, rb;
    beat_t nb;
    ra = (qa.size() < 2);
    rb = (qb.size() == 0) || rdy;
    nb.instr = instr;
    nb.pc    = pc;
    if (rst) begin
      qa.delete(); qb.delete();
      bub_a = 0; bub_b = 0;
      lpc_a = 0; lpc_b = 0;
    end else begin
      if (clr) begin
        bub_a = 0; bub_b = 0;
      end else begin
        if (qa.size() == 0 && bub_a < 15) bub_a++;
        if (qb.size() == 0 && bub_b < 65535) bub_b++;
      end
      if (flush) begin
        qa.delete(); qb.delete();
      end else begin
        if (qa.size() != 0 && rdy) void'(qa.pop_front());
        if (vld && ra) qa.push_back(nb);
        if (qb.size() != 0 && rdy) void'(qb.pop_front());
        if (vld && rb) qb.push_back(nb);
      end
      if (qa.size() != 0) lpc_a = qa[0].pc;
      if (qb.size() != 0) lpc_b = qb[0].pc;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit r, input bit f, input bit v, input logic [31:0] ins,
                       input logic [31:0] p, input bit rd, input bit c);
    rst = r; flush = f; vld = v; instr = ins; pc = p; rdy = rd; clr = c;
  endtask

  typedef struct {
    bit          rst, vld, rdy, clr;
    logic [31:0] pc;
    bit          ev;
    logic [31:0] epc;
    bit          er;
    int          eb;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h4, 1'b1, 32'h4, 1'b1, 1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 1'b1, 32'h8, 1'b1, 1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 1'b1, 32'h0, 1'b0, 1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 1'b1, 32'h0, 1'b0, 1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 1'b1, 32'h0, 1'b0, 1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 1'b1, 32'h4, 1'b1, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 1'b1, 32'h8, 1'b1, 1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 1'b0, 32'h8, 1'b1, 1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 1'b0, 32'h8, 1'b1, 2};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h8, 1'b0, 32'h8, 1'b1, 0};

    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_edge();
    #1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, 0, tbl[i].vld, 32'h1000_0000 | tbl[i].pc, tbl[i].pc, tbl[i].rdy, tbl[i].clr);
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(a_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_instr", i), a_instr, tbl[i].ev ? (32'h1000_0000 | tbl[i].epc) : NOP);
      chk($sformatf("tbl%0d_pc", i), a_pc, tbl[i].epc);
      chk($sformatf("tbl%0d_ready", i), 32'(a_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_bub", i), 32'(a_bub), 32'(tbl[i].eb));
    end

    // Flush with skid full: both held beats and the concurrent offer vanish.
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 32'h0050_0093, 32'h100, 0, 0); step();
    drive(0, 0, 1, 32'h00A0_0113, 32'h104, 0, 0); step();
    chk("flush_pre_ready", 32'(a_ready), 32'h0);
    drive(0, 1, 1, 32'h0DEA_D013, 32'h108, 0, 0); step();
    chk("flush_valid", 32'(a_valid), 32'h0);
    chk("flush_instr", a_instr, NOP);
    chk("flush_ready", 32'(a_ready), 32'h1);
    drive(0, 0, 0, 0, 0, 1, 0); step();
    chk("flush_nobeat", 32'(a_valid), 32'h0);

    // Bubble saturation at CNT_W=4, then clear.
    drive(1, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_a", 32'(a_bub), 32'd15);
    chk("sat_b", 32'(b_bub), 32'd20);
    drive(0, 0, 0, 0, 0, 1, 1); step();
    chk("clr_a", 32'(a_bub), 32'd0);
    chk("clr_b", 32'(b_bub), 32'd0);

    // No-skid: ready toggles combinationally with id_ready_i.
    drive(1, 0, 0, 0, 0, 1, 0); step();
    begin
      logic [31:0] npc;
      npc = 32'h200;
      for (int i = 0; i < 8; i++) begin
        drive(0, 0, 1, 32'h2000_0000 | npc, npc, (i % 2) == 0, 0);
        #1;
        chk($sformatf("nsk_ready%0d", i), 32'(b_ready), 32'((qb.size() == 0) || rdy));
        if ((qb.size() == 0) || rdy) npc = npc + 4;
        step();
      end
    end

    // Reset while the skid is full.
    drive(1, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 1, 32'h0000_1111, 32'h300, 0, 0); step();
    drive(0, 0, 1, 32'h0000_2222, 32'h304, 0, 0); step();
    drive(1, 0, 1, 32'h0000_3333, 32'h308, 0, 0); step();
    chk("mrst_valid", 32'(a_valid), 32'h0);
    chk("mrst_instr", a_instr, NOP);
    chk("mrst_pc", a_pc, 32'h0);
    chk("mrst_ready", 32'(a_ready), 32'h1);

    // Randomised traffic against the FIFO reference.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 60) == 0, ($urandom % 25) == 0, ($urandom % 4) != 0,
            $urandom, $urandom & 32'hFFFF_FFFC, ($urandom % 3) != 0, ($urandom % 40) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
